btn_toggle_debounce: RTL
========================

# btn_toggle_debounce

Debounces a raw mechanical pushbutton and turns each accepted press into exactly one single-cycle toggle-enable pulse. It sits directly upstream of the toggle flip-flop stage and drives that stage's T input, so each physical press flips the flop once. The block also reports the debounced button level and a running press count for status display.

## Interface
Parameters:
- SYNC_STAGES, 2: synchronizer flop depth on btn_in; legal range 2..4.
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized cycles required to accept a level change; legal range 1..65535.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): debounce counter width; derived, not overridden.
- PCNT_W, 8: press counter width.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset, asynchronous, active-high.
- btn_in  in  1  raw asynchronous button, 1 = pressed.
- t_pulse  out  1  registered toggle enable, high for exactly one cycle per accepted press.
- btn_level  out  1  debounced button level, registered.
- press_cnt  out  PCNT_W  accepted-press count; wraps from all-ones to 0.

## Operation
- btn_in passes through an SYNC_STAGES flop chain. sync_btn is the last stage. The FSM sees only sync_btn.
- FSM states and transitions:
  - IDLE (debounced released):
    - sync_btn=1 → PRESS_WAIT, cnt←0.
  - PRESS_WAIT:
    - sync_btn=0 → IDLE (bounce rejected, no pulse).
    - sync_btn=1 with cnt==DEBOUNCE_CYCLES-1 → PRESSED, t_pulse←1, btn_level←1, press_cnt←press_cnt+1.
    - Otherwise cnt←cnt+1.
  - PRESSED (debounced pressed):
    - sync_btn=0 → RELEASE_WAIT, cnt←0.
  - RELEASE_WAIT:
    - sync_btn=1 → PRESSED (bounce rejected, no pulse, btn_level stays 1).
    - sync_btn=0 with cnt==DEBOUNCE_CYCLES-1 → IDLE, btn_level←0.
    - Otherwise cnt←cnt+1.
- t_pulse returns to 0 on the cycle after any cycle in which it is 1. It never stays high for two consecutive cycles.
- A release never generates a pulse. A held button produces one pulse only; there is no auto-repeat.
- cnt never exceeds DEBOUNCE_CYCLES-1. It holds its value in IDLE and PRESSED.
- press_cnt uses modulo 2^PCNT_W arithmetic; 255+1 = 0 at the default width.

## Timing
- Reset values, applied immediately on rst assertion:
  - sync chain all 0, state IDLE, cnt 0.
  - t_pulse 0, btn_level 0, press_cnt 0.
- Press latency: btn_in is first sampled high at edge 1 and stays high. t_pulse and btn_level go high after edge SYNC_STAGES+1+DEBOUNCE_CYCLES (edge 19 at defaults). t_pulse falls after the next edge.
- Release latency: btn_level falls after edge SYNC_STAGES+1+DEBOUNCE_CYCLES, counted from the first sample of low.
- Any opposite-level sync_btn sample during PRESS_WAIT or RELEASE_WAIT aborts the wait. The full stable window restarts on the next qualifying edge.
- Reset mid-operation: rst asserted during PRESS_WAIT or while t_pulse is high clears everything at once. If the button is still held after release of rst, it is re-debounced from IDLE and produces a fresh pulse.
- rst deassertion is assumed synchronous to clk by the system reset bridge.

## Structure
- Shared package btn_pkg holds:
  - typedef enum logic [1:0] btn_state_t {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT};
  - localparam DEBOUNCE_DEFAULT = 16.
- One sub-module, bit_synchronizer:
  - Parameterized STAGES.
  - Asynchronous reset to 0.
  - Reused by other button and switch inputs in the design.
- Counter, FSM and output registers stay in the top module.

## Test plan
- Clean press, defaults: after reset, btn_in=1 held 40 cycles.
  - t_pulse high exactly at cycle 19 for 1 cycle.
  - btn_level=1 from cycle 19.
  - press_cnt=1.
- Bounce rejection, DEBOUNCE_CYCLES=4: btn_in pattern 1,1,0,1,0,1 then held high.
  - No pulse until 4 stable synchronized cycles have passed.
  - Exactly one pulse in total; press_cnt=1.
- Release bounce: while pressed, btn_in goes low for 2 cycles then high again (DEBOUNCE_CYCLES=4).
  - btn_level stays 1.
  - No new pulse; press_cnt unchanged.
- Wrap: 256 clean press/release cycles with DEBOUNCE_CYCLES=1.
  - press_cnt reads 0.
  - 256 pulses counted.
  - Toggle-flop model driven by t_pulse ends at its reset value.
- Reset mid-press: assert rst during PRESS_WAIT with cnt=10, then release rst with btn_in still high.
  - All outputs are 0 during reset.
  - Pulse occurs SYNC_STAGES+1+DEBOUNCE_CYCLES edges after rst release.
  - press_cnt=1.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared types and defaults for the pushbutton debounce blocks.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      PRESS_WAIT,
      PRESSED,
      RELEASE_WAIT
   } btn_state_t;

   localparam int unsigned DEBOUNCE_DEFAULT = 16;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchronizer for a single asynchronous bit; shared by all button and switch inputs.
module bit_synchronizer #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic [STAGES-1:0] chain;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) chain <= '0;
      else     chain <= {chain[STAGES-2:0], d};
   end

   assign q = chain[STAGES-1];

endmodule

// File: rtl/btn_toggle_debounce.sv
// Debounces a raw pushbutton and emits one single-cycle toggle enable per accepted press.
module btn_toggle_debounce
   import btn_pkg::*;
#(
   parameter  int unsigned SYNC_STAGES     = 2,
   parameter  int unsigned DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
   localparam int unsigned CNT_W           = $clog2(DEBOUNCE_CYCLES + 1),
   parameter  int unsigned PCNT_W          = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              btn_in,
   output logic              t_pulse,
   output logic              btn_level,
   output logic [PCNT_W-1:0] press_cnt
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic              sync_btn;
   btn_state_t        state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              t_pulse_nx, btn_level_nx;
   logic [PCNT_W-1:0] press_cnt_nx;
   logic              window_done;

   bit_synchronizer #(.STAGES(SYNC_STAGES)) u_sync (
      .clk (clk),
      .rst (rst),
      .d   (btn_in),
      .q   (sync_btn)
   );

   assign window_done = (cnt == CNT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         t_pulse   <= 1'b0;
         btn_level <= 1'b0;
         press_cnt <= '0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         t_pulse   <= t_pulse_nx;
         btn_level <= btn_level_nx;
         press_cnt <= press_cnt_nx;
      end
   end

   // cnt only moves inside the two wait states, so it holds in IDLE/PRESSED
   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      unique case (state)
         IDLE: begin
            if (sync_btn) begin
               state_nx = PRESS_WAIT;
               cnt_nx   = '0;
            end
         end
         PRESS_WAIT: begin
            if (!sync_btn)        state_nx = IDLE;
            else if (window_done) state_nx = PRESSED;
            else                  cnt_nx   = cnt + CNT_W'(1);
         end
         PRESSED: begin
            if (!sync_btn) begin
               state_nx = RELEASE_WAIT;
               cnt_nx   = '0;
            end
         end
         RELEASE_WAIT: begin
            if (sync_btn)         state_nx = PRESSED;
            else if (window_done) state_nx = IDLE;
            else                  cnt_nx   = cnt + CNT_W'(1);
         end
         default: begin
            state_nx = IDLE;
            cnt_nx   = '0;
         end
      endcase
   end

   always_comb begin
      t_pulse_nx   = 1'b0;
      btn_level_nx = btn_level;
      press_cnt_nx = press_cnt;
      if (state == PRESS_WAIT && sync_btn && window_done) begin
         t_pulse_nx   = 1'b1;
         btn_level_nx = 1'b1;
         press_cnt_nx = press_cnt + PCNT_W'(1);
      end else if (state == RELEASE_WAIT && !sync_btn && window_done) begin
         btn_level_nx = 1'b0;
      end
   end

endmodule
